// File: rtl/rst_pkg.sv
// Shared types and constants for the reset sequencer: FSM state encoding
// and the bit layout of the sticky reset-cause vector.
package rst_pkg;

    typedef enum logic [1:0] {
        RST_HOLD    = 2'd0,
        RST_STAGGER = 2'd1,
        RST_RUN     = 2'd2
    } rst_state_e;

    localparam int RST_CAUSE_W   = 4;
    localparam int RST_CAUSE_SW  = 0;
    localparam int RST_CAUSE_WDT = 1;
    localparam int RST_CAUSE_DBG = 2;
    localparam int RST_CAUSE_POR = 3;

    localparam logic [RST_CAUSE_W-1:0] RST_CAUSE_POR_VAL = 4'b1000;

endpackage

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: stretches the synchronized reset and in-system requests into
// registered core/peripheral resets, releasing peripherals first, and records why.
module rst_seq_ctrl
    import rst_pkg::*;
#(
    parameter int HOLD_CYCLES    = 16,
    parameter int STAGGER_CYCLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_i,
    input  logic                   dbg_rst_req_i,
    input  logic                   wdt_rst_req_i,
    input  logic                   sw_rst_req_i,
    input  logic                   cause_clr_i,
    output logic                   core_rst_o,
    output logic                   periph_rst_o,
    output logic                   busy_o,
    output logic [RST_CAUSE_W-1:0] cause_o
);

    localparam int CNT_MAX = (HOLD_CYCLES > STAGGER_CYCLES) ? HOLD_CYCLES : STAGGER_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] STAG_LD = CNT_W'(STAGGER_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    rst_state_e             state_r, state_d;
    logic [CNT_W-1:0]       cnt_r, cnt_d;
    logic [RST_CAUSE_W-1:0] cause_r, cause_d;
    logic                   core_rst_r, core_rst_d;
    logic                   periph_rst_r, periph_rst_d;
    logic                   busy_r, busy_d;
    logic                   req_s;
    logic [RST_CAUSE_W-1:0] req_vec_s;

    // Map the request lines onto their cause-bit positions
    always_comb begin
        req_vec_s                = '0;
        req_vec_s[RST_CAUSE_DBG] = dbg_rst_req_i;
        req_vec_s[RST_CAUSE_WDT] = wdt_rst_req_i;
        req_vec_s[RST_CAUSE_SW]  = sw_rst_req_i;
        req_s                    = dbg_rst_req_i | wdt_rst_req_i | sw_rst_req_i;
    end

    // Next-state, counter, cause and reset-output decode
    always_comb begin
        state_d      = state_r;
        cnt_d        = cnt_r;
        cause_d      = cause_r;
        core_rst_d   = core_rst_r;
        periph_rst_d = periph_rst_r;
        case (state_r)
            RST_HOLD: begin
                core_rst_d   = 1'b1;
                periph_rst_d = 1'b1;
                if (req_s) begin
                    cnt_d   = HOLD_LD;
                    cause_d = cause_r | req_vec_s;
                end else if (cnt_r <= CNT_ONE) begin
                    periph_rst_d = 1'b0;
                    if (STAGGER_CYCLES != 0) begin
                        state_d = RST_STAGGER;
                        cnt_d   = STAG_LD;
                    end else begin
                        core_rst_d = 1'b0;
                        state_d    = RST_RUN;
                        cnt_d      = '0;
                    end
                end else begin
                    cnt_d = cnt_r - CNT_ONE;
                end
            end
            RST_STAGGER: begin
                core_rst_d   = 1'b1;
                periph_rst_d = 1'b0;
                if (req_s) begin
                    state_d      = RST_HOLD;
                    cnt_d        = HOLD_LD;
                    periph_rst_d = 1'b1;
                    cause_d      = cause_r | req_vec_s;
                end else if (cnt_r <= CNT_ONE) begin
                    core_rst_d = 1'b0;
                    state_d    = RST_RUN;
                    cnt_d      = '0;
                end else begin
                    cnt_d = cnt_r - CNT_ONE;
                end
            end
            RST_RUN: begin
                core_rst_d   = 1'b0;
                periph_rst_d = 1'b0;
                if (req_s) begin
                    // A fresh reset episode starts: previous causes are discarded
                    state_d      = RST_HOLD;
                    cnt_d        = HOLD_LD;
                    cause_d      = req_vec_s;
                    core_rst_d   = 1'b1;
                    periph_rst_d = 1'b1;
                end else if (cause_clr_i) begin
                    cause_d = '0;
                end else begin
                    cause_d = cause_r;
                end
            end
            default: begin
                state_d      = RST_HOLD;
                cnt_d        = HOLD_LD;
                core_rst_d   = 1'b1;
                periph_rst_d = 1'b1;
            end
        endcase
        busy_d = (state_d != RST_RUN);
    end

    // State and output registers; rst_i wins over every request
    always_ff @(posedge clk) begin
        if (rst_i) begin
            state_r      <= RST_HOLD;
            cnt_r        <= HOLD_LD;
            cause_r      <= RST_CAUSE_POR_VAL;
            core_rst_r   <= 1'b1;
            periph_rst_r <= 1'b1;
            busy_r       <= 1'b1;
        end else begin
            state_r      <= state_d;
            cnt_r        <= cnt_d;
            cause_r      <= cause_d;
            core_rst_r   <= core_rst_d;
            periph_rst_r <= periph_rst_d;
            busy_r       <= busy_d;
        end
    end

    assign core_rst_o   = core_rst_r;
    assign periph_rst_o = periph_rst_r;
    assign busy_o       = busy_r;
    assign cause_o      = cause_r;

endmodule
